// File: rtl/sdram_read_pkg.sv
// Shared SDRAM sequencer definitions: command encodings {CS_n,RAS_n,CAS_n,WE_n},
// read-sequencer state encoding, timing constants in clock cycles at 100 MHz,
// and a helper that clamps a requested burst length to at least one word.
package sdram_read_pkg;

    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_READ   = 4'b0101;
    localparam logic [3:0] CMD_BST    = 4'b0110;
    localparam logic [3:0] CMD_PRE    = 4'b0010;

    // ACTIVE->READ wait, CAS latency (mode register A6..A4 = 011), PRECHARGE recovery
    localparam logic [2:0] TRCD_CLK = 3'd2;
    localparam logic [2:0] CAS_LAT  = 3'd3;
    localparam logic [2:0] TRP_CLK  = 3'd2;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ACTIVE  = 4'd1,
        S_TRCD    = 4'd2,
        S_READ    = 4'd3,
        S_CL      = 4'd4,
        S_RD_DATA = 4'd5,
        S_PRE     = 4'd6,
        S_TRP     = 4'd7,
        S_END     = 4'd8
    } rd_state_e;

    // A zero-length request is treated as a single-word read.
    function automatic logic [9:0] clamp_burst_len(input logic [9:0] len);
        logic [9:0] res;
        if (len == 10'd0) begin
            res = 10'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_read_if.sv
// Read-sequencer bus bundle.
//   slave  : the read sequencer (takes requests and DQ, drives commands and returned data)
//   master : the arbiter/SDRAM side (drives requests and DQ, observes commands and data)
interface sdram_read_if;
    logic        init_end;       // SDRAM initialisation complete
    logic        rd_en;          // read request (level)
    logic [22:0] rd_addr;        // [22:21] bank, [20:9] row, [8:0] start column
    logic [9:0]  rd_burst_len;   // words to read, 1..512 (0 read as 1)
    logic [15:0] rd_data;        // SDRAM DQ input
    logic        rd_ack;         // rd_sdram_data valid
    logic        rd_end;         // one-cycle completion pulse
    logic [3:0]  rd_cmd;         // {CS_n,RAS_n,CAS_n,WE_n}
    logic [1:0]  rd_ba;          // bank address
    logic [11:0] rd_sdram_addr;  // SDRAM address bus
    logic [15:0] rd_sdram_data;  // captured read word

    modport slave (
        input  init_end, rd_en, rd_addr, rd_burst_len, rd_data,
        output rd_ack, rd_end, rd_cmd, rd_ba, rd_sdram_addr, rd_sdram_data
    );

    modport master (
        output init_end, rd_en, rd_addr, rd_burst_len, rd_data,
        input  rd_ack, rd_end, rd_cmd, rd_ba, rd_sdram_addr, rd_sdram_data
    );
endinterface

// File: rtl/sdram_read.sv
// SDRAM read-side command sequencer.
// Issues ACTIVE, full-page READ, BURST_STOP and PRECHARGE for one request, captures
// the requested number of words from DQ after CAS latency and presents them with rd_ack.
// Ports:
//   sys_clk  - 100 MHz system clock
//   sys_rst  - synchronous active-high reset
//   rd_if    - sdram_read_if.slave bundle (request, DQ in, command/address/data out)
// All timing below is referenced to T0, the cycle READ is on rd_cmd.
module sdram_read
    import sdram_read_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    sdram_read_if.slave rd_if
);

    rd_state_e   state_q;
    logic [2:0]  wait_cnt_q;
    logic [9:0]  data_cnt_q;
    logic [9:0]  len_q;
    logic [1:0]  bank_q;
    logic [8:0]  col_q;
    logic [3:0]  cmd_q;
    logic [1:0]  ba_q;
    logic [11:0] addr_q;
    logic        ack_q;
    logic        end_q;
    logic [15:0] data_q;

    logic        start_d;
    logic        burst_stop_d;

    // Request acceptance; END also accepts so a held rd_en gives ACTIVE right after rd_end.
    always_comb begin
        start_d = 1'b0;
        if ((state_q == S_IDLE) || (state_q == S_END)) begin
            start_d = rd_if.rd_en && rd_if.init_end;
        end else begin
            start_d = 1'b0;
        end
    end

    // BURST_STOP must land on T0+len; decide one cycle early because rd_cmd is registered.
    // In CL, wait count k is cycle T0+1+k; in RD_DATA, data count j is cycle T0+CAS_LAT+1+j.
    always_comb begin
        burst_stop_d = 1'b0;
        case (state_q)
            S_READ:    burst_stop_d = (len_q == 10'd1);
            S_CL:      burst_stop_d = (len_q == ({7'd0, wait_cnt_q} + 10'd2));
            S_RD_DATA: burst_stop_d = (len_q == (data_cnt_q + {7'd0, CAS_LAT} + 10'd2));
            default:   burst_stop_d = 1'b0;
        endcase
    end

    // Sequencer FSM with registered command, address, ack, end and data outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            data_cnt_q <= 10'd0;
            len_q      <= 10'd0;
            bank_q     <= 2'b00;
            col_q      <= 9'd0;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'b11;
            addr_q     <= 12'hfff;
            ack_q      <= 1'b0;
            end_q      <= 1'b0;
            data_q     <= 16'h0000;
        end else begin
            cmd_q  <= burst_stop_d ? CMD_BST : CMD_NOP;
            ba_q   <= 2'b11;
            addr_q <= 12'hfff;
            ack_q  <= 1'b0;
            end_q  <= 1'b0;

            if (start_d) begin
                bank_q <= rd_if.rd_addr[22:21];
                col_q  <= rd_if.rd_addr[8:0];
                len_q  <= clamp_burst_len(rd_if.rd_burst_len);
            end

            case (state_q)
                S_IDLE, S_END: begin
                    if (start_d) begin
                        state_q <= S_ACTIVE;
                        cmd_q   <= CMD_ACTIVE;
                        ba_q    <= rd_if.rd_addr[22:21];
                        addr_q  <= rd_if.rd_addr[20:9];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    state_q    <= S_TRCD;
                    wait_cnt_q <= 3'd0;
                end
                S_TRCD: begin
                    if (wait_cnt_q == (TRCD_CLK - 3'd1)) begin
                        wait_cnt_q <= 3'd0;
                        state_q    <= S_READ;
                        cmd_q      <= CMD_READ;
                        ba_q       <= bank_q;
                        addr_q     <= {3'b000, col_q};  // A10=0: no auto-precharge
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                S_READ: begin
                    state_q    <= S_CL;
                    wait_cnt_q <= 3'd0;
                end
                S_CL: begin
                    if (wait_cnt_q == (CAS_LAT - 3'd1)) begin
                        // DQ now carries the first word; it is registered with its ack.
                        wait_cnt_q <= 3'd0;
                        data_cnt_q <= 10'd0;
                        state_q    <= S_RD_DATA;
                        ack_q      <= 1'b1;
                        data_q     <= rd_if.rd_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                S_RD_DATA: begin
                    if (data_cnt_q == (len_q - 10'd1)) begin
                        state_q <= S_PRE;
                        cmd_q   <= CMD_PRE;
                        addr_q  <= 12'hfff;  // A10=1: precharge all banks
                    end else begin
                        data_cnt_q <= data_cnt_q + 10'd1;
                        ack_q      <= 1'b1;
                        data_q     <= rd_if.rd_data;
                    end
                end
                S_PRE: begin
                    state_q    <= S_TRP;
                    wait_cnt_q <= 3'd0;
                end
                S_TRP: begin
                    if (wait_cnt_q == (TRP_CLK - 3'd1)) begin
                        wait_cnt_q <= 3'd0;
                        state_q    <= S_END;
                        end_q      <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    wait_cnt_q <= 3'd0;
                    data_cnt_q <= 10'd0;
                end
            endcase
        end
    end

    assign rd_if.rd_cmd        = cmd_q;
    assign rd_if.rd_ba         = ba_q;
    assign rd_if.rd_sdram_addr = addr_q;
    assign rd_if.rd_ack        = ack_q;
    assign rd_if.rd_end        = end_q;
    assign rd_if.rd_sdram_data = data_q;

endmodule

// File: tb/tb_sdram_read.sv
// Self-checking bench for sdram_read: table of read requests with hand-computed
// command offsets, an SDRAM data model feeding a scoreboard queue, and hand-written
// sequences for reset mid-burst and back-to-back requests.
module tb_sdram_read;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;

    typedef struct {
        logic [1:0]  bank;
        logic [11:0] row;
        logic [8:0]  col;
        logic [9:0]  len_in;
        int          exp_len;
        int          exp_act_addr;
        int          exp_rd_addr;
        int          exp_bst;   // BURST_STOP offset from T0
        int          exp_pre;   // PRECHARGE offset from T0
        int          exp_end;   // rd_end offset from T0
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    sdram_read_if bus();

    sdram_read dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rd_if   (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // observation log
    int act_n, act_cyc, act_ba, act_addr, rd_n, t0, rdc_ba, rdc_addr;
    int bst_n, bst_cyc, pre_n, pre_cyc, pre_addr, end_n, end_cyc, odd_n;
    int ack_n, ack_first, ack_last, ack_break, overlap_n;
    int act_gap[8];
    logic prev_ack;

    // SDRAM model state
    logic [1:0]  cur_bank;
    logic [11:0] cur_row;
    logic [8:0]  cur_col;
    int          cur_len;
    int          words_left;
    int          wi;
    logic [15:0] exp_q[$];

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word the modelled SDRAM returns; the column wraps within the 512-word page.
    function automatic logic [15:0] model_word(input int idx);
        logic [8:0] colw;
        colw = cur_col + 9'(idx);
        return {cur_bank, cur_row[4:0], colw};
    endfunction

    task automatic clear_log();
        act_n = 0; act_cyc = 0; act_ba = 0; act_addr = 0; rd_n = 0; t0 = 0;
        rdc_ba = 0; rdc_addr = 0; bst_n = 0; bst_cyc = 0; pre_n = 0; pre_cyc = 0;
        pre_addr = 0; end_n = 0; end_cyc = 0; odd_n = 0; ack_n = 0; ack_first = 0;
        ack_last = 0; ack_break = 0; overlap_n = 0; prev_ack = 1'b0;
        for (int k = 0; k < 8; k++) act_gap[k] = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive DQ for this cycle.
    task automatic step();
        @(negedge sys_clk);
        cyc++;
        case (bus.rd_cmd)
            C_ACT: begin
                if (act_n != end_n) overlap_n++;
                if (act_n < 8) act_gap[act_n] = cyc - end_cyc;
                act_n++; act_cyc = cyc;
                act_ba = int'(bus.rd_ba); act_addr = int'(bus.rd_sdram_addr);
            end
            C_RD: begin
                rd_n++; t0 = cyc; wi = 0; words_left = cur_len;
                rdc_ba = int'(bus.rd_ba); rdc_addr = int'(bus.rd_sdram_addr);
            end
            C_BST: begin bst_n++; bst_cyc = cyc; end
            C_PRE: begin pre_n++; pre_cyc = cyc; pre_addr = int'(bus.rd_sdram_addr); end
            C_NOP: ;
            default: odd_n++;
        endcase
        if (bus.rd_end === 1'b1) begin end_n++; end_cyc = cyc; end
        if (bus.rd_ack === 1'b1) begin
            if (!prev_ack && ack_n > 0) ack_break++;
            if (ack_n == 0) ack_first = cyc;
            ack_last = cyc;
            ack_n++;
            if (exp_q.size() == 0) begin
                check("ack_without_data", 1, 0);
            end else begin
                check("ack_data", int'(bus.rd_sdram_data), int'(exp_q.pop_front()));
            end
        end
        prev_ack = (bus.rd_ack === 1'b1);
        if (words_left > 0 && rd_n > 0 && cyc >= t0 + 3) begin
            bus.rd_data = model_word(wi);
            exp_q.push_back(bus.rd_data);
            wi++;
            words_left--;
        end else begin
            bus.rd_data = 16'($urandom());
        end
    endtask

    task automatic set_request(input logic [1:0] b, input logic [11:0] r,
                               input logic [8:0] c, input logic [9:0] l, input int el);
        cur_bank = b; cur_row = r; cur_col = c; cur_len = el;
        bus.rd_addr = {b, r, c};
        bus.rd_burst_len = l;
    endtask

    task automatic run_vector(input int i, input vec_t v);
        int n;
        clear_log();
        set_request(v.bank, v.row, v.col, v.len_in, v.exp_len);
        bus.rd_en = 1'b1;
        n = 0;
        while (act_n == 0 && n < 8) begin step(); n++; end
        bus.rd_en = 1'b0;
        n = 0;
        while (end_n == 0 && n < 600) begin step(); n++; end
        repeat (3) step();
        check($sformatf("v%0d_end_count", i), end_n, 1);
        check($sformatf("v%0d_act_count", i), act_n, 1);
        check($sformatf("v%0d_act_ba", i), act_ba, int'(v.bank));
        check($sformatf("v%0d_act_addr", i), act_addr, v.exp_act_addr);
        check($sformatf("v%0d_act_to_read", i), t0 - act_cyc, 3);
        check($sformatf("v%0d_read_ba", i), rdc_ba, int'(v.bank));
        check($sformatf("v%0d_read_addr", i), rdc_addr, v.exp_rd_addr);
        check($sformatf("v%0d_bst_count", i), bst_n, 1);
        check($sformatf("v%0d_bst_off", i), bst_cyc - t0, v.exp_bst);
        check($sformatf("v%0d_ack_count", i), ack_n, v.exp_len);
        check($sformatf("v%0d_ack_first", i), ack_first - t0, 4);
        check($sformatf("v%0d_ack_last", i), ack_last - t0, v.exp_len + 3);
        check($sformatf("v%0d_ack_break", i), ack_break, 0);
        check($sformatf("v%0d_pre_off", i), pre_cyc - t0, v.exp_pre);
        check($sformatf("v%0d_pre_addr", i), pre_addr, 'hfff);
        check($sformatf("v%0d_end_off", i), end_cyc - t0, v.exp_end);
        check($sformatf("v%0d_odd_cmd", i), odd_n, 0);
        check($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{2'd1, 12'h005, 9'h005, 10'd4,   4,   'h005, 'h005, 4,   8,   11};
        vecs[1] = '{2'd2, 12'hABC, 9'h1F0, 10'd1,   1,   'hABC, 'h1F0, 1,   5,   8};
        vecs[2] = '{2'd3, 12'h123, 9'h0FF, 10'd0,   1,   'h123, 'h0FF, 1,   5,   8};
        vecs[3] = '{2'd0, 12'hFFF, 9'h1FE, 10'd3,   3,   'hFFF, 'h1FE, 3,   7,   10};
        vecs[4] = '{2'd2, 12'h0F0, 9'h010, 10'd2,   2,   'h0F0, 'h010, 2,   6,   9};
        vecs[5] = '{2'd1, 12'h007, 9'h000, 10'd512, 512, 'h007, 'h000, 512, 516, 519};

        sys_rst = 1'b1;
        bus.init_end = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_data = 16'h0000;
        words_left = 0;
        wi = 0;
        clear_log();
        set_request(2'd1, 12'h005, 9'h005, 10'd4, 4);
        repeat (3) step();
        check("rst_cmd", int'(bus.rd_cmd), int'(C_NOP));
        check("rst_ba", int'(bus.rd_ba), 3);
        check("rst_addr", int'(bus.rd_sdram_addr), 'hfff);
        check("rst_ack", int'(bus.rd_ack), 0);
        check("rst_end", int'(bus.rd_end), 0);
        check("rst_data", int'(bus.rd_sdram_data), 0);

        // Requests are ignored until initialisation completes.
        sys_rst = 1'b0;
        bus.rd_en = 1'b1;
        clear_log();
        repeat (20) step();
        check("noinit_cmds", act_n + rd_n + bst_n + pre_n + odd_n, 0);
        check("noinit_ack", ack_n, 0);
        check("noinit_cmd_now", int'(bus.rd_cmd), int'(C_NOP));
        bus.rd_en = 1'b0;
        step();
        bus.init_end = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

        // Reset during RD_DATA after two acks, then a fresh request.
        clear_log();
        set_request(2'd2, 12'h333, 9'h040, 10'd8, 8);
        bus.rd_en = 1'b1;
        n = 0;
        while (act_n == 0 && n < 8) begin step(); n++; end
        bus.rd_en = 1'b0;
        n = 0;
        while (ack_n < 2 && n < 40) begin step(); n++; end
        check("midrst_acks_before", ack_n, 2);
        sys_rst = 1'b1;
        step();
        check("midrst_cmd", int'(bus.rd_cmd), int'(C_NOP));
        check("midrst_ack", int'(bus.rd_ack), 0);
        check("midrst_data", int'(bus.rd_sdram_data), 0);
        check("midrst_addr", int'(bus.rd_sdram_addr), 'hfff);
        sys_rst = 1'b0;
        words_left = 0;
        exp_q.delete();
        repeat (12) step();
        check("midrst_no_more_ack", ack_n, 2);
        check("midrst_no_pre", pre_n + end_n, 0);
        run_vector(6, vecs[0]);

        // rd_en held high: back-to-back sequences; init_end drop in the last one is ignored.
        clear_log();
        set_request(2'd3, 12'h0A5, 9'h1FF, 10'd2, 2);
        bus.rd_en = 1'b1;
        n = 0;
        while (end_n < 3 && n < 200) begin step(); n++; end
        step();
        check("b2b_rearm", act_n, 4);
        bus.rd_en = 1'b0;
        bus.init_end = 1'b0;
        n = 0;
        while (end_n < 4 && n < 60) begin step(); n++; end
        repeat (3) step();
        bus.init_end = 1'b1;
        check("b2b_ends", end_n, 4);
        check("b2b_acts", act_n, 4);
        check("b2b_reads", rd_n, 4);
        check("b2b_acks", ack_n, 8);
        check("b2b_bsts", bst_n, 4);
        check("b2b_pres", pre_n, 4);
        check("b2b_overlap", overlap_n, 0);
        for (int k = 1; k < 4; k++) check($sformatf("b2b_gap%0d", k), act_gap[k], 1);
        check("b2b_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
